// File: rtl/lsu_mem_ctrl_if.sv
// CPU-side load/store request/response and RAM-side word port of the LSU.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller for a word-wide little-endian RAM;
// sub-word stores go through a read-modify-write, bad accesses never reach the RAM.
module lsu_mem_lane (
  input  logic       sel,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] out_b
);
  assign out_b = sel ? new_b : old_b;
endmodule

module lsu_mem_ctrl #(
  parameter int ADDR_LIMIT = 1024
) (
  input logic            clk,
  input logic            rst_n,
  lsu_mem_ctrl_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t state, state_n;

  // latched request fields needed after the accept edge
  logic        we_q, signed_q;
  logic [1:0]  size_q, addr_q;
  logic [15:0] wdata_q;

  logic        re_r, we_r, rv_r, rerr_r;
  logic [31:0] maddr_r, mwdata_r, rdata_r;
  logic        re_n, we_n, rv_n, rerr_n;
  logic [31:0] maddr_n, mwdata_n, rdata_n;

  logic accept, req_err;

  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_re     = re_r;
  assign bus.mem_we     = we_r;
  assign bus.mem_addr   = maddr_r;
  assign bus.mem_wdata  = mwdata_r;
  assign bus.resp_valid = rv_r;
  assign bus.resp_err   = rerr_r;
  assign bus.resp_rdata = rdata_r;

  assign accept  = bus.req_valid && (state == IDLE);
  assign req_err = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
                   (bus.req_addr >= 32'(ADDR_LIMIT));

  // sub-word merge: replicate store data across lanes, then pick lanes by mask
  logic [NUM_LANES-1:0]            lane_sel;
  logic [NUM_LANES-1:0][VEC_W-1:0] old_w, new_w, mrg_w;

  assign old_w = bus.mem_rdata;
  assign new_w = (size_q == 2'b00) ? {4{wdata_q[7:0]}} : {2{wdata_q}};

  always_comb begin
    lane_sel = '0;
    if (size_q == 2'b00) lane_sel[addr_q] = 1'b1;
    else                 lane_sel = addr_q[1] ? 4'b1100 : 4'b0011;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_mem_lane u_lane (
      .sel   (lane_sel[i]),
      .old_b (old_w[i]),
      .new_b (new_w[i]),
      .out_b (mrg_w[i])
    );
  end

  // load extraction; valid halves have addr_q[0]==0 so one byte shifter serves both
  logic [31:0] ld_sh, ld_ext;
  assign ld_sh = bus.mem_rdata >> {addr_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   ld_ext = signed_q ? {{24{ld_sh[7]}}, ld_sh[7:0]}   : {24'b0, ld_sh[7:0]};
      2'b01:   ld_ext = signed_q ? {{16{ld_sh[15]}}, ld_sh[15:0]} : {16'b0, ld_sh[15:0]};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_n  = state;
    re_n     = 1'b0;
    we_n     = 1'b0;
    rv_n     = 1'b0;
    rerr_n   = 1'b0;
    rdata_n  = '0;
    maddr_n  = maddr_r;
    mwdata_n = mwdata_r;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_n = RESP;
            rv_n    = 1'b1;
            rerr_n  = 1'b1;
          end else if (!bus.req_we || bus.req_size != 2'b10) begin
            state_n = RD;
            re_n    = 1'b1;
            maddr_n = {bus.req_addr[31:2], 2'b00};
          end else begin
            state_n  = WR;
            we_n     = 1'b1;
            maddr_n  = {bus.req_addr[31:2], 2'b00};
            mwdata_n = bus.req_wdata;
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_n  = WR;
          we_n     = 1'b1;
          mwdata_n = mrg_w;
        end else begin
          state_n = RESP;
          rv_n    = 1'b1;
          rdata_n = ld_ext;
        end
      end
      WR: begin
        state_n = RESP;
        rv_n    = 1'b1;
      end
      RESP: begin
        state_n  = IDLE;
        maddr_n  = '0;
        mwdata_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_r     <= 1'b0;
      we_r     <= 1'b0;
      rv_r     <= 1'b0;
      rerr_r   <= 1'b0;
      rdata_r  <= '0;
      maddr_r  <= '0;
      mwdata_r <= '0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= 2'b00;
      wdata_q  <= '0;
    end else begin
      re_r     <= re_n;
      we_r     <= we_n;
      rv_r     <= rv_n;
      rerr_r   <= rerr_n;
      rdata_r  <= rdata_n;
      maddr_r  <= maddr_n;
      mwdata_r <= mwdata_n;
      if (accept) begin
        we_q     <= bus.req_we;
        signed_q <= bus.req_signed;
        size_q   <= bus.req_size;
        addr_q   <= bus.req_addr[1:0];
        wdata_q  <= bus.req_wdata[15:0];
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a combinational 1 KB word RAM model.
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b0;
  int   vecs = 0;
  int   miss = 0;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.ADDR_LIMIT(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:255];
  assign bus.mem_rdata = ram[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[4] <= 32'h8899AABB;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One request, then watch 6 cycles; cycle 1 is the cycle right after accept.
  task automatic xact(input string tag, input logic we, input logic [1:0] size,
                      input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_re, input int exp_we, input logic [31:0] exp_wdata);
    int lat = 0, nresp = 0, nre = 0, nwe = 0, both = 0;
    logic [31:0] rd = '0, re_addr = '0, we_addr = '0, we_data = '0;
    logic er = 1'b0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        nresp++;
        if (lat == 0) lat = c;
        rd = bus.resp_rdata;
        er = bus.resp_err;
      end
      if (bus.mem_re) begin nre++; re_addr = bus.mem_addr; end
      if (bus.mem_we) begin nwe++; we_addr = bus.mem_addr; we_data = bus.mem_wdata; end
      if (bus.mem_re && bus.mem_we) both++;
    end
    check({tag, ".lat"},   32'(lat),   32'(exp_lat));
    check({tag, ".nresp"}, 32'(nresp), 32'd1);
    check({tag, ".rdata"}, rd,         exp_rdata);
    check({tag, ".err"},   32'(er),    32'(exp_err));
    check({tag, ".nre"},   32'(nre),   32'(exp_re));
    check({tag, ".nwe"},   32'(nwe),   32'(exp_we));
    check({tag, ".both"},  32'(both),  32'd0);
    if (exp_re > 0) check({tag, ".re_addr"}, re_addr, {addr[31:2], 2'b00});
    if (exp_we > 0) begin
      check({tag, ".we_addr"}, we_addr, {addr[31:2], 2'b00});
      check({tag, ".wdata"},   we_data, exp_wdata);
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    preload        = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst.resp_err",   32'(bus.resp_err),   32'd0);
    check("rst.mem_re",     32'(bus.mem_re),     32'd0);
    check("rst.mem_we",     32'(bus.mem_we),     32'd0);
    check("rst.mem_addr",   bus.mem_addr,        32'h0);
    check("rst.mem_wdata",  bus.mem_wdata,       32'h0);
    check("rst.resp_rdata", bus.resp_rdata,      32'h0);
    rst_n = 1'b1;

    // loads: tag, we, size, signed, addr, wdata, lat, rdata, err, nre, nwe, wdata
    xact("lb12",  1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 2, 32'hFFFFFF99, 1'b0, 1, 0, 32'h0);
    xact("lbu12", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 2, 32'h00000099, 1'b0, 1, 0, 32'h0);
    xact("lh12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 32'hFFFF8899, 1'b0, 1, 0, 32'h0);
    xact("lhu10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, 32'h0000AABB, 1'b0, 1, 0, 32'h0);
    xact("lw10",  1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 2, 32'h8899AABB, 1'b0, 1, 0, 32'h0);
    xact("lb13u", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 32'h00000088, 1'b0, 1, 0, 32'h0);
    xact("lw3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 2, 32'h00000000, 1'b0, 1, 0, 32'h0);

    // byte store read-modify-write, then read back
    xact("sb11",  1'b1, 2'b00, 1'b0, 32'h11, 32'h123456CC, 3, 32'h0, 1'b0, 1, 1, 32'h8899CCBB);
    xact("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'h8899CCBB, 1'b0, 1, 0, 32'h0);
    xact("sh12",  1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 3, 32'h0, 1'b0, 1, 1, 32'h1234CCBB);
    xact("sh10",  1'b1, 2'b01, 1'b0, 32'h10, 32'h00008899, 3, 32'h0, 1'b0, 1, 1, 32'h12348899);
    xact("sb13",  1'b1, 2'b00, 1'b0, 32'h13, 32'h00000088, 3, 32'h0, 1'b0, 1, 1, 32'h88348899);
    xact("sb12",  1'b1, 2'b00, 1'b0, 32'h12, 32'h00000099, 3, 32'h0, 1'b0, 1, 1, 32'h88998899);
    xact("sh10b", 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000CCBB, 3, 32'h0, 1'b0, 1, 1, 32'h8899CCBB);

    // word store with req_valid held through the busy period
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.req_we    = 1'b0;
    @(negedge clk);
    check("sw.c1.we",    32'(bus.mem_we),    32'd1);
    check("sw.c1.re",    32'(bus.mem_re),    32'd0);
    check("sw.c1.ready", 32'(bus.req_ready), 32'd0);
    check("sw.c1.wdata", bus.mem_wdata,      32'hDEADBEEF);
    check("sw.c1.addr",  bus.mem_addr,       32'h20);
    @(negedge clk);
    check("sw.c2.resp",  32'(bus.resp_valid), 32'd1);
    check("sw.c2.err",   32'(bus.resp_err),   32'd0);
    check("sw.c2.ready", 32'(bus.req_ready),  32'd0);
    check("sw.c2.we",    32'(bus.mem_we),     32'd0);
    check("sw.c2.wdata", bus.mem_wdata,       32'hDEADBEEF);
    @(negedge clk);
    check("sw.c3.ready", 32'(bus.req_ready),  32'd1);
    check("sw.c3.resp",  32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("lw20.c1.re",  32'(bus.mem_re),   32'd1);
    check("lw20.c1.adr", bus.mem_addr,      32'h20);
    @(negedge clk);
    check("lw20.c2.resp", 32'(bus.resp_valid), 32'd1);
    check("lw20.c2.data", bus.resp_rdata,      32'hDEADBEEF);

    // errors: never touch memory, respond in cycle 1
    xact("esh11",  1'b1, 2'b01, 1'b0, 32'h11,  32'hFFFF, 1, 32'h0, 1'b1, 0, 0, 32'h0);
    xact("elw3fe", 1'b0, 2'b10, 1'b0, 32'h3FE, 32'h0,    1, 32'h0, 1'b1, 0, 0, 32'h0);
    xact("elw400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0,    1, 32'h0, 1'b1, 0, 0, 32'h0);
    xact("esz3",   1'b0, 2'b11, 1'b0, 32'h0,   32'h0,    1, 32'h0, 1'b1, 0, 0, 32'h0);
    xact("elb400", 1'b0, 2'b00, 1'b1, 32'h400, 32'h0,    1, 32'h0, 1'b1, 0, 0, 32'h0);
    xact("esw2",   1'b1, 2'b10, 1'b0, 32'h22,  32'h1,    1, 32'h0, 1'b1, 0, 0, 32'h0);

    // reset mid-write: the sub-word store must be dropped entirely
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h11;
    bus.req_wdata = 32'h00000077;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstwr.c1.re", 32'(bus.mem_re), 32'd1);
    @(negedge clk);
    check("rstwr.c2.we", 32'(bus.mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstwr.we_drop", 32'(bus.mem_we), 32'd0);
    check("rstwr.resp",    32'(bus.resp_valid), 32'd0);
    check("rstwr.addr",    bus.mem_addr, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rstwr.noresp", 32'(bus.resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rstwr.ready", 32'(bus.req_ready), 32'd1);
    check("rstwr.noresp2", 32'(bus.resp_valid), 32'd0);
    xact("lw10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'h8899CCBB, 1'b0, 1, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
